// File: rtl/image_send.sv
// Streams an image from byte memory to a UART: SOH, ASCII header, chunked data with ACKs, ETX, then waits for SYN.
// Optional wait-state timeout enabled by defining IMAGE_SEND_TIMEOUT_EN.
module image_send #(
   parameter int unsigned CHUNK_SIZE     = 256,
   parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] img_len,
   input  logic [7:0]  img_sum,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned   CW         = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
   localparam logic [CW-1:0] CHUNK_LAST = CW'(CHUNK_SIZE - 1);
   localparam logic [7:0]    SOH        = 8'h01;
   localparam logic [7:0]    ETX        = 8'h03;
   localparam logic [7:0]    ACK        = 8'h06;
   localparam logic [7:0]    SYN        = 8'h16;
   localparam logic [7:0]    COMMA      = 8'h2C;

   typedef enum logic [3:0] {
      IDLE,
      SEND_SOH,
      SEND_HDR,
      WAIT_READY,
      FETCH,
      SEND_DATA,
      WAIT_ACK,
      SEND_END,
      WAIT_SYN,
      FAIL
   } state_t;

   state_t         state_q, state_d;
   logic [15:0]    len_q, len_d;
   logic [15:0]    addr_q, addr_d;
   logic [7:0]     sum_q, sum_d;
   logic [7:0]     tx_byte_q, tx_byte_d;
   logic           tx_valid_q, tx_valid_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           ready_q, ready_d;
   logic [2:0]     hdr_idx_q, hdr_idx_d;
   logic [CW-1:0]  chunk_q, chunk_d;

   logic [15:0]    remaining;
   logic           tx_accept;
   logic           rx_ack;
   logic           rx_syn;
   logic           in_wait;
   logic           tmo_hit;

   assign remaining = len_q - addr_q;
   assign tx_accept = tx_valid_q && tx_ready;
   assign rx_ack    = rx_valid && (rx_data == ACK);
   assign rx_syn    = rx_valid && (rx_data == SYN);
   assign in_wait   = (state_q == WAIT_READY) || (state_q == WAIT_ACK) || (state_q == WAIT_SYN);

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Header layout: LLLL,SS with uppercase hex, most significant nibble first.
   function automatic logic [7:0] hdr_char(input logic [2:0] idx, input logic [15:0] len,
                                           input logic [7:0] sum);
      logic [7:0] c;
      case (idx)
         3'd0:    c = hex_char(len[15:12]);
         3'd1:    c = hex_char(len[11:8]);
         3'd2:    c = hex_char(len[7:4]);
         3'd3:    c = hex_char(len[3:0]);
         3'd4:    c = COMMA;
         3'd5:    c = hex_char(sum[7:4]);
         default: c = hex_char(sum[3:0]);
      endcase
      return c;
   endfunction

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      sum_d      = sum_q;
      addr_d     = addr_q;
      chunk_d    = chunk_q;
      hdr_idx_d  = hdr_idx_q;
      tx_byte_d  = tx_byte_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ready_d    = ready_q;

      // READY may arrive at any point once SOH has gone out, so it is remembered.
      if (rx_ack && (((state_q != IDLE) && (state_q != SEND_SOH)) ||
                     ((state_q == SEND_SOH) && tx_accept))) begin
         ready_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SEND_SOH;
               len_d      = img_len;
               sum_d      = img_sum;
               addr_d     = '0;
               chunk_d    = '0;
               hdr_idx_d  = '0;
               ready_d    = 1'b0;
               busy_d     = 1'b1;
               tx_byte_d  = SOH;
               tx_valid_d = 1'b1;
            end
         end
         SEND_SOH: begin
            if (tx_accept) begin
               state_d   = SEND_HDR;
               tx_byte_d = hdr_char(3'd0, len_q, sum_q);
            end
         end
         SEND_HDR: begin
            if (tx_accept) begin
               if (hdr_idx_q == 3'd6) begin
                  tx_valid_d = 1'b0;
                  state_d    = WAIT_READY;
               end else begin
                  hdr_idx_d = hdr_idx_q + 3'd1;
                  tx_byte_d = hdr_char(hdr_idx_q + 3'd1, len_q, sum_q);
               end
            end
         end
         WAIT_READY: begin
            if (ready_q || rx_ack) begin
               if (remaining == '0) begin
                  state_d    = SEND_END;
                  tx_byte_d  = ETX;
                  tx_valid_d = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end else if (tmo_hit) begin
               state_d = FAIL;
               busy_d  = 1'b0;
            end
         end
         FETCH: begin
            state_d    = SEND_DATA;
            tx_valid_d = 1'b1;
         end
         SEND_DATA: begin
            if (tx_accept) begin
               addr_d     = addr_q + 16'd1;
               chunk_d    = chunk_q + CW'(1);
               tx_valid_d = 1'b0;
               if (chunk_q == CHUNK_LAST) begin
                  state_d = WAIT_ACK;
               end else if (remaining == 16'd1) begin
                  state_d    = SEND_END;
                  tx_byte_d  = ETX;
                  tx_valid_d = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         WAIT_ACK: begin
            if (rx_ack) begin
               if (remaining == '0) begin
                  state_d    = SEND_END;
                  tx_byte_d  = ETX;
                  tx_valid_d = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end else if (tmo_hit) begin
               state_d = FAIL;
               busy_d  = 1'b0;
            end
         end
         SEND_END: begin
            if (tx_accept) begin
               tx_valid_d = 1'b0;
               tx_byte_d  = '0;
               state_d    = WAIT_SYN;
            end
         end
         WAIT_SYN: begin
            if (rx_syn) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (tmo_hit) begin
               state_d = FAIL;
               busy_d  = 1'b0;
            end
         end
         FAIL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         sum_q      <= '0;
         addr_q     <= '0;
         chunk_q    <= '0;
         hdr_idx_q  <= '0;
         tx_byte_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         sum_q      <= sum_d;
         addr_q     <= addr_d;
         chunk_q    <= chunk_d;
         hdr_idx_q  <= hdr_idx_d;
         tx_byte_q  <= tx_byte_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end

`ifdef IMAGE_SEND_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   logic        error_q, error_d;

   assign tmo_hit = in_wait && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

   // The counter restarts on every state change so each wait gets a full budget.
   always_comb begin
      tmo_d = '0;
      if (in_wait && (state_d == state_q)) begin
         tmo_d = tmo_q + 32'd1;
      end
      error_d = error_q;
      if ((state_q == IDLE) && start) begin
         error_d = 1'b0;
      end else if (state_d == FAIL) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q   <= '0;
         error_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   assign tmo_hit = 1'b0;
   assign error   = 1'b0;

   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
`endif

   assign rd_addr  = addr_q;
   assign tx_data  = (state_q == SEND_DATA) ? rd_data : tx_byte_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_image_send.sv
// Directed bench for image_send: expected UART bytes are queued when a transfer is started
// and compared against bytes the DUT hands over.
module tb_image_send;

   localparam int unsigned CHUNK = 256;
   localparam int unsigned TMO   = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] img_len;
   logic [7:0]  img_sum;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        busy;
   logic        done;
   logic        error;

   logic [7:0]  mem [0:1023];
   logic [7:0]  obs_q [$];
   logic [7:0]  exp_q [$];
   int          obs_idx  = 0;
   int          done_cnt = 0;
   int          checks   = 0;
   int          errors   = 0;

   image_send #(.CHUNK_SIZE(CHUNK), .TIMEOUT_CYCLES(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .img_len  (img_len),
      .img_sum  (img_sum),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr[9:0]];

   always @(negedge clk) begin
      if (tx_valid && tx_ready) obs_q.push_back(tx_data);
      if (done) done_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic start_img(input logic [15:0] len, input logic [7:0] sum);
      img_len = len;
      img_sum = sum;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      string digits;
      digits = "0123456789ABCDEF";
      return digits[n];
   endfunction

   task automatic push_hdr(input logic [15:0] len, input logic [7:0] sum);
      exp_q.push_back(8'h01);
      exp_q.push_back(hex_ascii(len[15:12]));
      exp_q.push_back(hex_ascii(len[11:8]));
      exp_q.push_back(hex_ascii(len[7:4]));
      exp_q.push_back(hex_ascii(len[3:0]));
      exp_q.push_back(8'h2C);
      exp_q.push_back(hex_ascii(sum[7:4]));
      exp_q.push_back(hex_ascii(sum[3:0]));
   endtask

   task automatic wait_obs(input int budget, input string tag);
      int n;
      n = 0;
      while ((obs_q.size() < obs_idx + exp_q.size()) && (n < budget)) begin
         tick();
         n++;
      end
      check(tag, 32'(obs_q.size() >= obs_idx + exp_q.size()), 32'd1);
   endtask

   task automatic drain(input string tag);
      logic [7:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_idx < obs_q.size()) begin
            check(tag, obs_q[obs_idx], e);
            obs_idx++;
         end else begin
            check({tag, "_missing"}, obs_q.size(), obs_idx + 1);
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tx_valid"}, tx_valid, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_error"}, error, 1'b0);
      check({tag, "_tx_data"}, tx_data, 8'h00);
      check({tag, "_rd_addr"}, rd_addr, 16'h0000);
   endtask

   initial begin
      int d0;
      int t0;
      int k;
      int n;

      rst      = 1'b1;
      start    = 1'b0;
      tx_ready = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      img_len  = 16'h0000;
      img_sum  = 8'h00;
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      mem[2] = 8'h33;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // Three-byte image, READY after the header.
      start_img(16'd3, 8'hA5);
      push_hdr(16'd3, 8'hA5);
      wait_obs(40, "t1_hdr_wait");
      drain("t1_hdr");
      repeat (5) tick();
      check("t1_hold_for_ready", obs_q.size(), obs_idx);
      check("t1_busy", busy, 1'b1);
      rx_byte(8'h06);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h03);
      wait_obs(40, "t1_data_wait");
      drain("t1_data");
      rx_byte(8'h55);
      d0 = done_cnt;
      rx_byte(8'h16);
      repeat (3) tick();
      check("t1_done_once", done_cnt - d0, 1);
      check("t1_busy_off", busy, 1'b0);
      check("t1_no_extra", obs_q.size(), obs_idx);

      // 512 bytes in two full chunks, each waiting for its ACK; mid-chunk backpressure.
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
      t0 = obs_q.size();
      start_img(16'd512, 8'h5A);
      push_hdr(16'd512, 8'h5A);
      wait_obs(40, "t2_hdr_wait");
      drain("t2_hdr");
      rx_byte(8'h06);
      for (int i = 0; i < 256; i++) exp_q.push_back(mem[i]);
      wait_obs(2000, "t2_chunk0_wait");
      drain("t2_chunk0");
      repeat (20) tick();
      check("t2_stall_ack0", obs_q.size(), obs_idx);
      rx_byte(8'h06);
      n = 0;
      while ((obs_q.size() < t0 + 8 + 256 + 5) && (n < 100)) begin
         tick();
         n++;
      end
      n = 0;
      while (!tx_valid && (n < 10)) begin
         tick();
         n++;
      end
      check("t2_bp_setup", tx_valid, 1'b1);
      tx_ready = 1'b0;
      k = obs_q.size() - t0 - 8;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("t2_bp_valid", tx_valid, 1'b1);
         check("t2_bp_data", tx_data, mem[k]);
         check("t2_bp_addr", rd_addr, 16'(k));
      end
      tx_ready = 1'b1;
      for (int i = 256; i < 512; i++) exp_q.push_back(mem[i]);
      wait_obs(2000, "t2_chunk1_wait");
      drain("t2_chunk1");
      repeat (20) tick();
      check("t2_no_etx_before_ack", obs_q.size(), obs_idx);
      rx_byte(8'h06);
      exp_q.push_back(8'h03);
      wait_obs(20, "t2_etx_wait");
      drain("t2_etx");
      d0 = done_cnt;
      rx_byte(8'h16);
      repeat (3) tick();
      check("t2_done_once", done_cnt - d0, 1);
      check("t2_busy_off", busy, 1'b0);

      // Empty image; READY arrives while the header is still going out.
      start_img(16'd0, 8'h3C);
      push_hdr(16'd0, 8'h3C);
      tick();
      tick();
      rx_byte(8'h06);
      exp_q.push_back(8'h03);
      wait_obs(40, "t3_wait");
      drain("t3");
      d0 = done_cnt;
      rx_byte(8'h16);
      repeat (3) tick();
      check("t3_done_once", done_cnt - d0, 1);
      check("t3_busy_off", busy, 1'b0);
      check("t3_no_extra", obs_q.size(), obs_idx);

      // Reset in the middle of a chunk, then a stray 0x06 must not restart anything.
      t0 = obs_q.size();
      start_img(16'd512, 8'h00);
      n = 0;
      while ((obs_q.size() < t0 + 8) && (n < 40)) begin
         tick();
         n++;
      end
      rx_byte(8'h06);
      n = 0;
      while ((obs_q.size() < t0 + 28) && (n < 200)) begin
         tick();
         n++;
      end
      check("t4_mid_chunk", 32'(obs_q.size() >= t0 + 28), 32'd1);
      rst = 1'b1;
      #1;
      check_idle_outputs("t4_in_reset");
      tick();
      check_idle_outputs("t4_in_reset_clk");
      rst = 1'b0;
      tick();
      t0 = obs_q.size();
      rx_byte(8'h06);
      repeat (20) tick();
      check("t4_no_restart", obs_q.size(), t0);
      check("t4_idle_busy", busy, 1'b0);
      check("t4_idle_valid", tx_valid, 1'b0);
      obs_idx = obs_q.size();
      exp_q.delete();

      // No READY at all.
      start_img(16'd4, 8'h00);
      push_hdr(16'd4, 8'h00);
      wait_obs(40, "t5_hdr_wait");
      drain("t5_hdr");
`ifdef IMAGE_SEND_TIMEOUT_EN
      repeat (90) tick();
      check("t5_early_error", error, 1'b0);
      check("t5_early_busy", busy, 1'b1);
      n = 0;
      while (!error && (n < 30)) begin
         tick();
         n++;
      end
      check("t5_timeout_error", error, 1'b1);
      check("t5_timeout_busy", busy, 1'b0);
      tick();
      start_img(16'd4, 8'h00);
      check("t5_error_cleared", error, 1'b0);
      check("t5_restart_busy", busy, 1'b1);
`else
      repeat (150) tick();
      check("t5_no_timeout_error", error, 1'b0);
      check("t5_still_waiting", busy, 1'b1);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("t5_final_idle", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
